// File: rtl/furv_mem_arb_if.sv
// ---------------------------------------------------------------------------
// furv_mem_arb_if
//
// Bundle of every bus signal around the fetch/data memory arbiter. It covers
// the fetch requester, the load/store requester, the shared memory port and
// the two status outputs.
//
// Handshake semantics (both requester ports and the memory port):
//   A request is a level. The requester raises *_req and holds it, together
//   with every address/data field, until the responder signals completion.
//   Completion on a requester port is a single-cycle *_ack pulse from the
//   arbiter, with *_rdata valid in that same cycle. Completion on the memory
//   port is mem_ack from memory, with mem_rdata valid in that same cycle. The
//   arbiter drops mem_req in the cycle after mem_ack. A requester may keep
//   req high during its own ack cycle; the arbiter does not treat that as a
//   new request.
//
// Modports:
//   slave  - the arbiter: it receives requests and drives the memory port.
//   master - the environment: the requesters and the memory model.
// ---------------------------------------------------------------------------
interface furv_mem_arb_if #(
    parameter int ADDR_W = 32
);
    // Fetch requester.
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;

    // Load/store requester.
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_wstrb;
    logic              d_ack;
    logic [31:0]       d_rdata;

    // Shared memory port.
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    // Status.
    logic              if_stall;
    logic              busy;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_ack, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata,
        output if_stall, busy
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_ack, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata,
        input  if_stall, busy
    );
endinterface

// File: rtl/furv_mem_arb.sv
// ---------------------------------------------------------------------------
// furv_mem_arb
//
// Shares the core's single memory port between instruction fetch and
// load/store. The arbiter serves one request at a time:
//   1. In IDLE it picks one eligible requester.
//   2. It registers that requester's fields onto the memory bus and holds
//      them stable.
//   3. It waits for mem_ack. The wait can last any number of cycles.
//   4. On the cycle after mem_ack it pulses the owner's ack and returns to
//      IDLE, with the owner's rdata updated.
//
// Data normally wins a tie. A fairness bit (last_data) hands the next tie to
// fetch whenever the previous grant went to data, so fetch cannot starve.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   bus       - furv_mem_arb_if.slave (fetch port, data port, memory port,
//               if_stall, busy)
//   state_dbg - current FSM state (0 IDLE, 1 FETCH, 2 DATA), for observation
//
// Timing: a request seen in IDLE at cycle N puts mem_req high at N+1. If
// mem_ack arrives at cycle M, the owner's ack pulses at M+1 and the arbiter is
// back in IDLE at M+1. With zero-wait memory this gives one access every three
// cycles.
// ---------------------------------------------------------------------------
module furv_mem_arb #(
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    furv_mem_arb_if.slave        bus,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_data_q, last_data_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;

    // A requester whose ack is high this cycle still holds req. Masking it
    // here stops that already-served request from being granted a second
    // time.
    logic fetch_elig;
    logic data_elig;
    logic grant_data;
    logic grant_fetch;

    assign fetch_elig  = bus.if_req && !if_ack_q;
    assign data_elig   = bus.d_req && !d_ack_q;
    // Data takes a tie unless it also won the previous grant.
    assign grant_data  = data_elig && (!fetch_elig || !last_data_q);
    assign grant_fetch = fetch_elig && !grant_data;

    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                // mem_ack arriving here belongs to no transaction and is ignored.
                if (grant_data) begin
                    state_d     = DATA;
                    last_data_d = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    mem_wstrb_d = bus.d_wstrb;
                end else if (grant_fetch) begin
                    state_d     = FETCH;
                    last_data_d = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    // Fetches are always word-aligned reads.
                    mem_addr_d  = {bus.if_addr[ADDR_W-1:2], 2'b00};
                    mem_wdata_d = 32'd0;
                    mem_wstrb_d = 4'd0;
                end
            end
            FETCH: begin
                if (bus.mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    if_rdata_d = bus.mem_rdata;
                end
            end
            DATA: begin
                if (bus.mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    d_ack_d   = 1'b1;
                    // Stores also capture mem_rdata; the value is simply unused.
                    d_rdata_d = bus.mem_rdata;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // An asynchronous reset aborts any transaction in flight. No ack is
    // produced for it, and a later mem_ack lands in IDLE and is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_data_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            mem_wstrb_q <= 4'd0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

    // if_stall is combinational so the fetch stage freezes in the same cycle
    // it raises a request.
    assign bus.if_stall  = bus.if_req && !if_ack_q;
    assign bus.busy      = (state_q != IDLE);
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_furv_mem_arb.sv
module tb_furv_mem_arb;
  localparam int ADDR_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] state_dbg;

  furv_mem_arb_if #(.ADDR_W(ADDR_W)) bus ();

  furv_mem_arb #(.ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  // ---------------- reference model state ----------------
  // Requests issued by the drivers that have not been granted yet.
  bit f_pend = 0, d_pend = 0;
  logic [31:0] f_addr_m;
  logic        d_we_m;
  logic [31:0] d_addr_m, d_wdata_m;
  logic [3:0]  d_wstrb_m;
  // Transaction-level view of the arbiter.
  bit m_busy = 0, m_owner = 0, m_last_data = 0;
  bit ack_f_now = 0, ack_d_now = 0;
  logic [31:0] m_if_rdata = 0, m_d_rdata = 0;
  // Scoreboards: {owner, rdata} acks and {we, addr, wdata, wstrb} memory requests.
  logic [32:0] exp_q[$];
  logic [68:0] mem_q[$];
  logic [68:0] cur_txn = '0;
  bit prev_mem_req = 0;
  bit mon_en = 0;
  bit mem_en = 0;
  int mem_wait = 0;

  task automatic model_reset();
    f_pend = 0; d_pend = 0;
    m_busy = 0; m_owner = 0; m_last_data = 0;
    ack_f_now = 0; ack_d_now = 0;
    m_if_rdata = 0; m_d_rdata = 0;
    exp_q.delete(); mem_q.delete();
    prev_mem_req = 0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit af, ad, ef, ed;
  logic [32:0] e_ack;
  always @(negedge clk) begin
    if (mon_en) begin
      af = ack_f_now;
      ad = ack_d_now;
      chk("if_ack", bus.if_ack, af);
      chk("d_ack", bus.d_ack, ad);
      if (bus.if_ack === 1'b1 || bus.d_ack === 1'b1) begin
        if (exp_q.size() == 0) fail_now("ack_without_completion");
        else begin
          e_ack = exp_q.pop_front();
          if (e_ack[32]) m_d_rdata = e_ack[31:0];
          else m_if_rdata = e_ack[31:0];
        end
      end
      chk("if_rdata", bus.if_rdata, m_if_rdata);
      chk("d_rdata", bus.d_rdata, m_d_rdata);
      chk("busy", bus.busy, m_busy);
      chk("mem_req", bus.mem_req, m_busy);
      chk("if_stall", bus.if_stall, bus.if_req && !af);
      chk("state_dbg_idle", state_dbg == 2'd0, !m_busy);
      if (bus.mem_req === 1'b1 && !prev_mem_req) begin
        if (mem_q.size() == 0) fail_now("mem_req_without_grant");
        else cur_txn = mem_q.pop_front();
      end
      if (bus.mem_req === 1'b1)
        chk("mem_fields", {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}, cur_txn);
      prev_mem_req = (bus.mem_req === 1'b1);

      // Advance the model to the next cycle.
      ack_f_now = 0;
      ack_d_now = 0;
      if (m_busy) begin
        if (bus.mem_ack === 1'b1) begin
          exp_q.push_back({m_owner, bus.mem_rdata});
          if (m_owner) ack_d_now = 1; else ack_f_now = 1;
          m_busy = 0;
        end
      end else begin
        // A requester being acked this cycle cannot be granted again.
        ef = f_pend && !af;
        ed = d_pend && !ad;
        if (ed && (!ef || !m_last_data)) begin
          mem_q.push_back({d_we_m, d_addr_m, d_wdata_m, d_wstrb_m});
          d_pend = 0; m_last_data = 1; m_owner = 1; m_busy = 1;
        end else if (ef) begin
          mem_q.push_back({1'b0, f_addr_m & 32'hFFFF_FFFC, 32'd0, 4'd0});
          f_pend = 0; m_last_data = 0; m_owner = 0; m_busy = 1;
        end
      end
    end
  end

  // ---------------- memory driver ----------------
  always @(posedge clk) begin
    if (mem_en) begin
      #1;
      if (bus.mem_ack) bus.mem_ack = 1'b0;
      else if (bus.mem_req) begin
        if (mem_wait == 0) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = $urandom;
          mem_wait = $urandom_range(0, 3);
        end else mem_wait--;
      end else if ($urandom_range(0, 15) == 0) begin
        // Stray ack while idle; the arbiter must ignore it.
        bus.mem_ack = 1'b1;
        bus.mem_rdata = $urandom;
      end
    end
  end

  // ---------------- requester drivers ----------------
  task automatic fetch_driver(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      bus.if_addr = $urandom;
      f_addr_m = bus.if_addr;
      bus.if_req = 1'b1;
      f_pend = 1;
      t = 0;
      do begin @(posedge clk); #1; t++; end while (bus.if_ack !== 1'b1 && t < 200);
      if (bus.if_ack !== 1'b1) fail_now("fetch_ack_timeout");
      bus.if_req = 1'b0;
    end
  endtask

  task automatic data_driver(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      bus.d_we = 1'($urandom_range(0, 1));
      bus.d_addr = $urandom;
      bus.d_wdata = $urandom;
      bus.d_wstrb = 4'($urandom_range(0, 15));
      d_we_m = bus.d_we; d_addr_m = bus.d_addr;
      d_wdata_m = bus.d_wdata; d_wstrb_m = bus.d_wstrb;
      bus.d_req = 1'b1;
      d_pend = 1;
      t = 0;
      do begin @(posedge clk); #1; t++; end while (bus.d_ack !== 1'b1 && t < 200);
      if (bus.d_ack !== 1'b1) fail_now("data_ack_timeout");
      bus.d_req = 1'b0;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    bus.if_req = 0; bus.if_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_wstrb = 0;
    bus.mem_ack = 0; bus.mem_rdata = 0;

    // Reset values, before any clock edge.
    #1;
    chk("rst_mem", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}, 70'd0);
    chk("rst_acks", {bus.if_ack, bus.d_ack}, 2'b00);
    chk("rst_rdata", {bus.if_rdata, bus.d_rdata}, 64'd0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_state", state_dbg, 2'd0);
    bus.if_req = 1'b1;
    #1;
    chk("rst_if_stall_follows_req", bus.if_stall, 1'b1);
    bus.if_req = 1'b0;
    #1;
    chk("rst_if_stall_low", bus.if_stall, 1'b0);

    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1;
    mem_en = 1;

    // Random contention phase: both requesters against a random-latency memory.
    fork
      fetch_driver(40);
      data_driver(40);
    join
    repeat (6) begin @(posedge clk); #1; end
    mem_en = 0;
    bus.mem_ack = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("random_acks_drained", exp_q.size(), 0);
    chk("random_grants_drained", mem_q.size(), 0);

    // Stalled memory: a fetch waits 10+ cycles; the monitor checks stability.
    bus.if_addr = 32'h0000_0103;
    f_addr_m = bus.if_addr;
    bus.if_req = 1'b1;
    f_pend = 1;
    repeat (12) begin @(posedge clk); #1; end
    chk("stall_addr", bus.mem_addr, 32'h0000_0100);
    chk("stall_busy", bus.busy, 1'b1);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h0000_0013;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    chk("stall_if_ack", bus.if_ack, 1'b1);
    chk("stall_if_rdata", bus.if_rdata, 32'h0000_0013);
    bus.if_req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Reset in the middle of a store.
    bus.d_we = 1'b1; bus.d_addr = 32'h0000_2002;
    bus.d_wdata = 32'hAABB_CCDD; bus.d_wstrb = 4'hC;
    d_we_m = 1'b1; d_addr_m = 32'h0000_2002; d_wdata_m = 32'hAABB_CCDD; d_wstrb_m = 4'hC;
    bus.d_req = 1'b1;
    d_pend = 1;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_reset_mem_req", bus.mem_req, 1'b1);
    chk("pre_reset_fields", {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb},
        {1'b1, 32'h0000_2002, 32'hAABB_CCDD, 4'hC});
    #2;
    mon_en = 0;
    bus.if_req = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}, 70'd0);
    chk("async_rst_acks", {bus.if_ack, bus.d_ack}, 2'b00);
    chk("async_rst_rdata", {bus.if_rdata, bus.d_rdata}, 64'd0);
    chk("async_rst_busy", bus.busy, 1'b0);
    chk("async_rst_if_stall", bus.if_stall, 1'b1);
    bus.if_req = 1'b0;
    bus.d_req = 1'b0;
    model_reset();
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    mon_en = 1;
    // A late ack for the aborted store must be ignored.
    @(posedge clk); #1;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("late_ack_no_d_ack", exp_q.size(), 0);
    chk("late_ack_d_rdata", bus.d_rdata, 32'd0);
    mon_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/furv_mem_arb.md
# furv_mem_arb

Two-requester arbiter sharing the core's single memory port between the instruction fetch stage and the load/store stage. It registers one request at a time onto the memory bus, waits for a variable-latency acknowledge, and returns read data and a one-cycle ack to the owner. Data accesses normally win; a fairness bit prevents fetch starvation. It also reports a fetch-stall indication that drives the fetch stage's stall input.

## Interface
- ADDR_W, 32, address width for all address ports
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held with if_addr stable until if_ack
- if_addr  in  ADDR_W  fetch address (low 2 bits ignored)
- if_ack  out  1  one-cycle pulse: if_rdata valid, request retired
- if_rdata  out  32  fetched instruction word
- d_req  in  1  data request; held with d_* stable until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address, passed unmodified
- d_wdata  in  32  store data
- d_wstrb  in  4  store byte enables
- d_ack  out  1  one-cycle pulse: d_rdata valid (loads), request retired
- d_rdata  out  32  load data
- mem_req  out  1  memory request, held until mem_ack
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/ADDR_W/32/4  registered request fields
- mem_ack  in  1  memory completes current request this cycle
- mem_rdata  in  32  read data, valid with mem_ack
- if_stall  out  1  if_req high and if_ack low (combinational)
- busy  out  1  state != IDLE

## Operation
- States: IDLE, FETCH, DATA. Fairness bit last_data (1 = previous grant was data).
- IDLE: eligible fetch = if_req && !if_ack; eligible data = d_req && !d_ack (masks the requester being acked this cycle, which still holds req).
  - Only one eligible: grant it.
  - Both eligible: grant data if last_data == 0, else fetch.
  - On grant: register mem_addr/we/wdata/wstrb, set mem_req = 1, go to FETCH or DATA, update last_data.
- Fetch grant: mem_addr = {if_addr[ADDR_W-1:2], 2'b00}, mem_we = 0, mem_wstrb = 0, mem_wdata = 0.
- Data grant: fields copied from d_* verbatim.
- FETCH/DATA: hold all mem_* stable; on mem_ack: mem_req <= 0, owner ack <= 1, owner rdata <= mem_rdata (also loaded on stores; value irrelevant), state <= IDLE.
- if_rdata/d_rdata hold their last value between acks.
- mem_ack in IDLE is ignored (no ack, no data update).
- Requester dropping req before its ack: undefined by contract; the arbiter completes the memory transaction anyway and still pulses ack.

## Timing
- Reset (async assert): state IDLE, last_data 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, if_ack 0, d_ack 0, if_rdata 0, d_rdata 0; busy 0; if_stall follows if_req.
- Request seen in IDLE at cycle N: mem_req high from N+1.
- mem_ack at cycle M (M >= N+1): owner ack and rdata at M+1, state IDLE at M+1.
- Minimum turnaround: req N, mem_ack N+1, ack N+2. Next grant can be decided at N+2 (mem_req N+3). One access per 3 cycles at zero-wait memory.
- Reset mid-transaction: mem_req drops immediately; no ack is generated for the aborted request; a late mem_ack after reset is ignored.
- Simultaneous arrival of both requests plus an ack to one of them: the acked requester is masked that cycle; the other is granted.

## Test plan
- Lone fetch: reset, if_req=1, if_addr=0x103, mem_ack 2 cycles after mem_req with rdata=0x00000013 -> mem_addr=0x100, mem_we=0, wstrb=0; if_ack one pulse, if_rdata=0x13; if_stall high until the ack cycle.
- Lone store: d_req=1, d_we=1, d_addr=0x2002, d_wdata=0xAABBCCDD, d_wstrb=0xC -> mem fields identical; d_ack one pulse after mem_ack; no if_ack.
- Contention: if_req and d_req both held from reset, zero-wait memory -> grants alternate D,F,D,F (data first); each ack one pulse; no duplicate access to the same requester while its ack is high.
- Back-to-back fetches with zero-wait memory: if_addr 0x0,0x4,0x8 advanced on each if_ack -> exactly one memory read per address, 3-cycle spacing.
- Reset mid-DATA: assert rst_n low while mem_req high -> all outputs to reset values asynchronously; mem_ack pulsed after release is ignored (no d_ack).
- Stalled memory: mem_ack withheld 10 cycles -> mem_* fields stable throughout, busy=1, no acks, if_stall high for the waiting fetch.
